// File: rtl/rab_miss_arbiter.sv
// Round-robin arbitration of per-port RAB misses into a single miss FIFO that
// software drains through the config register read path.
module rab_miss_arbiter #(
  parameter int  N_PORTS        = 3,
  parameter int  C_AXI_ID_WIDTH = 8,
  parameter int  FIFO_DEPTH     = 4,
  localparam int PORT_ID_WIDTH  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int LVL_WIDTH      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                     s_axi_aclk,
  input  logic                                     s_axi_aresetn,
  input  logic [N_PORTS-1:0]                       miss_valid_i,
  input  logic [N_PORTS*32-1:0]                    miss_addr_i,
  input  logic [N_PORTS*C_AXI_ID_WIDTH-1:0]        miss_id_i,
  output logic [N_PORTS-1:0]                       miss_ready_o,
  input  logic                                     pop_i,
  input  logic                                     clear_i,
  output logic                                     head_valid_o,
  output logic [31:0]                              head_addr_o,
  output logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0]  head_id_o,
  output logic                                     fifo_full_o,
  output logic [LVL_WIDTH-1:0]                     fifo_level_o,
  output logic                                     stall_o
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int HID_WIDTH   = PORT_ID_WIDTH + C_AXI_ID_WIDTH;
  localparam int ENTRY_WIDTH = HID_WIDTH + 32;
  localparam int PEXT_W      = PORT_ID_WIDTH + 1;

  localparam logic [LVL_WIDTH-1:0]     LVL_FULL  = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0]     LVL_ZERO  = {LVL_WIDTH{1'b0}};
  localparam logic [LVL_WIDTH-1:0]     LVL_ONE   = LVL_WIDTH'(1);
  localparam logic [PEXT_W-1:0]        PORTS_EXT = PEXT_W'(N_PORTS);
  localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT = PORT_ID_WIDTH'(N_PORTS - 1);
  localparam logic [PORT_ID_WIDTH-1:0] PORT_ZERO = {PORT_ID_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0]     PTR_ZERO  = {PTR_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0]     PTR_ONE   = PTR_WIDTH'(1);

  logic [ENTRY_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [ENTRY_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_WIDTH-1:0]     count_q, count_d;
  logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                     grant_found_s;
  logic [PORT_ID_WIDTH-1:0] grant_idx_s;
  logic [PEXT_W-1:0]        cand_s;
  logic                     grant_s;
  logic                     pop_s;
  logic [ENTRY_WIDTH-1:0]   wr_entry_s;
  logic [ENTRY_WIDTH-1:0]   head_entry_s;

  // Round-robin search: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = PORT_ZERO;
    cand_s        = {PEXT_W{1'b0}};
    for (int i = 0; i < N_PORTS; i++) begin
      cand_s = {1'b0, rr_ptr_q} + PEXT_W'(i);
      if (cand_s >= PORTS_EXT) begin
        cand_s = cand_s - PORTS_EXT;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && miss_valid_i[cand_s[PORT_ID_WIDTH-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PORT_ID_WIDTH-1:0];
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Grant/pop qualification; a full FIFO blocks the grant even when popping
  // so that pop_i never reaches miss_ready_o combinationally.
  always_comb begin
    grant_s = grant_found_s & (count_q != LVL_FULL) & ~clear_i & s_axi_aresetn;
    pop_s   = pop_i & (count_q != LVL_ZERO) & ~clear_i;
    for (int p = 0; p < N_PORTS; p++) begin
      miss_ready_o[p] = grant_s && (grant_idx_s == PORT_ID_WIDTH'(p));
    end
    wr_entry_s = {grant_idx_s,
                  miss_id_i[grant_idx_s*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH],
                  miss_addr_i[grant_idx_s*32 +: 32]};
  end

  // Next-state for pointers, occupancy and round-robin position.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (clear_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = LVL_ZERO;
      rr_ptr_d = PORT_ZERO;
    end else begin
      if (grant_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (grant_idx_s == LAST_PORT) begin
          rr_ptr_d = PORT_ZERO;
        end else begin
          rr_ptr_d = grant_idx_s + PORT_ID_WIDTH'(1);
        end
      end else begin
        wr_ptr_d = wr_ptr_q;
        rr_ptr_d = rr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({grant_s, pop_s})
        2'b10:   count_d = count_q + LVL_ONE;
        2'b01:   count_d = count_q - LVL_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write on grant.
  always_comb begin
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      mem_d[k] = mem_q[k];
    end
    if (grant_s) begin
      mem_d[wr_ptr_q] = wr_entry_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
  end

  // State registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= LVL_ZERO;
      rr_ptr_q <= PORT_ZERO;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= {ENTRY_WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  // Head view and status; head fields read as zero while empty.
  always_comb begin
    head_entry_s = mem_q[rd_ptr_q];
    head_valid_o = (count_q != LVL_ZERO);
    if (head_valid_o) begin
      head_addr_o = head_entry_s[31:0];
      head_id_o   = head_entry_s[ENTRY_WIDTH-1:32];
    end else begin
      head_addr_o = 32'h0000_0000;
      head_id_o   = {HID_WIDTH{1'b0}};
    end
    fifo_full_o  = (count_q == LVL_FULL);
    fifo_level_o = count_q;
    stall_o      = fifo_full_o & (|miss_valid_i);
  end

  rab_miss_arbiter_chk #(
    .N_PORTS    (N_PORTS),
    .LVL_WIDTH  (LVL_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .clear (clear_i),
    .full  (fifo_full_o),
    .ready (miss_ready_o),
    .level (fifo_level_o)
  );

endmodule

// Protocol checker for the arbiter: one-hot grant, blocked grant when full or
// clearing, and bounded occupancy.
module rab_miss_arbiter_chk #(
  parameter int N_PORTS    = 3,
  parameter int LVL_WIDTH  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clear,
  input logic                 full,
  input logic [N_PORTS-1:0]   ready,
  input logic [LVL_WIDTH-1:0] level
);

  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ready));
  a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n)
    full |-> (ready == {N_PORTS{1'b0}}));
  a_clear_blocks: assert property (@(posedge clk) disable iff (!rst_n)
    clear |-> (ready == {N_PORTS{1'b0}}));
  a_clear_empties: assert property (@(posedge clk) disable iff (!rst_n)
    clear |=> (level == {LVL_WIDTH{1'b0}}));
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level <= LVL_FULL);

endmodule
